// File: rtl/sat_pkg.sv
// sat_pkg: types and constants shared by the SAT solver blocks.
//   imply_entry_t : one implied assignment {var_idx, val}
//   IMPLY_CNT_W   : occupancy-count width of a full-size implication stack
// `MAX_VARS / `MAX_VARS_BITS normally come from sysdefs.svh. The fallbacks below
// let this slice elaborate on its own.
`ifndef MAX_VARS
`define MAX_VARS 16
`endif
`ifndef MAX_VARS_BITS
`define MAX_VARS_BITS 4
`endif

package sat_pkg;
   typedef struct packed {
      logic [`MAX_VARS_BITS-1:0] var_idx;
      logic                      val;
   } imply_entry_t;

   localparam int IMPLY_CNT_W = $clog2(`MAX_VARS + 1);
endpackage

// File: rtl/imply_stack_stats.sv
// imply_stack_stats: occupancy high-water mark and accepted-push counter.
//   clock, reset     : clock; synchronous active-high reset
//   clear            : solver flush (clears high_water only)
//   push_acc         : a push is accepted this cycle
//   cnt_nxt          : occupancy the stack will hold after this edge
//   high_water       : max occupancy since reset/clear
//   push_total       : saturating count of accepted pushes (reset only)
module imply_stack_stats #(
   parameter int CNT_W = 5
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             clear,
   input  logic             push_acc,
   input  logic [CNT_W-1:0] cnt_nxt,
   output logic [CNT_W-1:0] high_water,
   output logic [15:0]      push_total
);
   always_ff @(posedge clock) begin
      if (reset) begin
         high_water <= '0;
         push_total <= '0;
      end else begin
         if (clear)
            high_water <= '0;
         else if (cnt_nxt > high_water)
            high_water <= cnt_nxt;
         if (push_acc && push_total != 16'hFFFF)
            push_total <= push_total + 16'd1;
      end
   end
endmodule

// File: rtl/imply_stack.sv
// imply_stack: LIFO of implied variable assignments.
// Pushed by the conflict detector, popped by the propagation dispatcher over a
// valid/ready port, flushed by the solver on conflict/backtrack.
//   clock, reset            : clock; synchronous active-high reset
//   clear                   : synchronous flush (beats push/pop)
//   push_en/push_var_idx/push_val : push side
//   pop_ready/pop_valid/pop_var_idx/pop_val : pop side, top = mem[count-1]
//   count, empty, full      : occupancy
//   overflow                : sticky, a push was dropped while full
//   high_water, push_total  : statistics, built only with IMPLY_STACK_STATS_EN
//                             (tied to 0 otherwise)
module imply_stack
   import sat_pkg::*;
#(
   parameter int  DEPTH = `MAX_VARS,
   parameter int  IDX_W = `MAX_VARS_BITS,
   localparam int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             clear,
   input  logic             push_en,
   input  logic [IDX_W-1:0] push_var_idx,
   input  logic             push_val,
   input  logic             pop_ready,
   output logic             pop_valid,
   output logic [IDX_W-1:0] pop_var_idx,
   output logic             pop_val,
   output logic [CNT_W-1:0] count,
   output logic             empty,
   output logic             full,
   output logic             overflow,
   output logic [CNT_W-1:0] high_water,
   output logic [15:0]      push_total
);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [IDX_W-1:0] mem_idx [DEPTH];
   logic             mem_val [DEPTH];

   logic             pop_fire, push_ok;
   logic [AW-1:0]    rd_addr, wr_addr;
   logic [CNT_W-1:0] cnt_nxt;
   logic             ovf_nxt;

   assign empty     = (count == '0);
   assign full      = (count == CNT_W'(DEPTH));
   assign pop_valid = !empty;
   assign pop_fire  = pop_valid && pop_ready;
   // A full stack still takes a push when the top is leaving this cycle.
   assign push_ok   = push_en && (!full || pop_fire);

   // rd_addr wraps when empty; its contents are don't-care then.
   assign rd_addr     = AW'(count - CNT_W'(1));
   // Push+pop replaces the current top in place.
   assign wr_addr     = pop_fire ? rd_addr : AW'(count);
   assign pop_var_idx = mem_idx[rd_addr];
   assign pop_val     = mem_val[rd_addr];

   always_comb begin
      cnt_nxt = count;
      ovf_nxt = overflow;
      if (clear) begin
         cnt_nxt = '0;
         ovf_nxt = 1'b0;
      end else begin
         if (push_ok && !pop_fire)
            cnt_nxt = count + CNT_W'(1);
         else if (pop_fire && !push_ok)
            cnt_nxt = count - CNT_W'(1);
         if (push_en && full && !pop_fire)
            ovf_nxt = 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         count    <= cnt_nxt;
         overflow <= ovf_nxt;
      end
   end

   // Storage carries no reset.
   always_ff @(posedge clock) begin
      if (!reset && !clear && push_ok) begin
         mem_idx[wr_addr] <= push_var_idx;
         mem_val[wr_addr] <= push_val;
      end
   end

`ifdef IMPLY_STACK_STATS_EN
   imply_stack_stats #(.CNT_W(CNT_W)) u_stats (
      .clock      (clock),
      .reset      (reset),
      .clear      (clear),
      .push_acc   (push_ok && !clear),
      .cnt_nxt    (cnt_nxt),
      .high_water (high_water),
      .push_total (push_total)
   );
`else
   assign high_water = '0;
   assign push_total = '0;
`endif
endmodule

// File: tb/tb_imply_stack.sv
module tb_imply_stack;
   logic       clock = 1'b0;
   logic       reset;
   always #5 clock = ~clock;

   // DEPTH=4 instance: functional tests
   logic       clear, push_en, push_val, pop_ready;
   logic [3:0] push_var_idx;
   logic       pop_valid, pop_val, empty, full, overflow;
   logic [3:0] pop_var_idx;
   logic [2:0] count, high_water;
   logic [15:0] push_total;

   // DEPTH=8 instance: statistics test
   logic       s_clear, s_push_en, s_push_val, s_pop_ready;
   logic [3:0] s_push_var_idx;
   logic       s_pop_valid, s_pop_val, s_empty, s_full, s_overflow;
   logic [3:0] s_pop_var_idx;
   logic [3:0] s_count, s_high_water;
   logic [15:0] s_push_total;

   int n_cmp = 0;
   int n_err = 0;

   imply_stack #(.DEPTH(4), .IDX_W(4)) u_dut (
      .clock(clock), .reset(reset), .clear(clear),
      .push_en(push_en), .push_var_idx(push_var_idx), .push_val(push_val),
      .pop_ready(pop_ready), .pop_valid(pop_valid), .pop_var_idx(pop_var_idx),
      .pop_val(pop_val), .count(count), .empty(empty), .full(full),
      .overflow(overflow), .high_water(high_water), .push_total(push_total)
   );

   imply_stack #(.DEPTH(8), .IDX_W(4)) u_dut8 (
      .clock(clock), .reset(reset), .clear(s_clear),
      .push_en(s_push_en), .push_var_idx(s_push_var_idx), .push_val(s_push_val),
      .pop_ready(s_pop_ready), .pop_valid(s_pop_valid), .pop_var_idx(s_pop_var_idx),
      .pop_val(s_pop_val), .count(s_count), .empty(s_empty), .full(s_full),
      .overflow(s_overflow), .high_water(s_high_water), .push_total(s_push_total)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Inputs change 1 time unit after the edge; checks run in the same window.
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic idle();
      clear = 0; push_en = 0; pop_ready = 0; push_var_idx = 0; push_val = 0;
   endtask

   task automatic push(input logic [3:0] idx, input logic v);
      push_en = 1; push_var_idx = idx; push_val = v;
      tick();
      idle();
   endtask

   task automatic do_clear();
      clear = 1;
      tick();
      idle();
   endtask

   task automatic s_push(input logic [3:0] idx);
      s_push_en = 1; s_push_var_idx = idx; s_push_val = 1;
      tick();
      s_push_en = 0;
   endtask

   initial begin
      reset = 1; idle();
      s_clear = 0; s_push_en = 0; s_push_val = 0; s_pop_ready = 0; s_push_var_idx = 0;
      tick(); tick();
      reset = 0;

      // reset state
      chk("rst_count", 32'(count), 0);
      chk("rst_empty", 32'(empty), 1);
      chk("rst_full", 32'(full), 0);
      chk("rst_pop_valid", 32'(pop_valid), 0);
      chk("rst_overflow", 32'(overflow), 0);
      chk("rst_high_water", 32'(high_water), 0);
      chk("rst_push_total", 32'(push_total), 0);

      // 1: LIFO order
      push(5, 1); push(9, 0); push(12, 1);
      chk("t1_count3", 32'(count), 3);
      pop_ready = 1;
      chk("t1_pop1", {pop_valid, pop_var_idx, pop_val}, {1'b1, 4'd12, 1'b1});
      tick();
      chk("t1_pop2", {pop_valid, pop_var_idx, pop_val}, {1'b1, 4'd9, 1'b0});
      tick();
      chk("t1_pop3", {pop_valid, pop_var_idx, pop_val}, {1'b1, 4'd5, 1'b1});
      tick();
      idle();
      chk("t1_empty", 32'(empty), 1);
      chk("t1_pop_valid0", 32'(pop_valid), 0);

      // pop_ready while empty is ignored
      pop_ready = 1; tick(); idle();
      chk("pop_empty_count", 32'(count), 0);

      // 2: push-to-pop latency
      push(3, 1);
      chk("t2_top", {pop_valid, pop_var_idx, pop_val}, {1'b1, 4'd3, 1'b1});
      chk("t2_count", 32'(count), 1);

      // 3: simultaneous push and pop replaces top
      do_clear();
      push(4, 0); push(7, 1);
      push_en = 1; push_var_idx = 8; push_val = 0; pop_ready = 1;
      chk("t3_pop", {pop_valid, pop_var_idx, pop_val}, {1'b1, 4'd7, 1'b1});
      tick(); idle();
      chk("t3_count", 32'(count), 2);
      chk("t3_top", {pop_var_idx, pop_val}, {4'd8, 1'b0});
      pop_ready = 1; tick(); idle();
      chk("t3_below", {pop_var_idx, pop_val}, {4'd4, 1'b0});

      // 4: overflow at DEPTH=4
      do_clear();
      push(1, 0); push(2, 0); push(3, 0); push(4, 1);
      chk("t4_full_pre", 32'(full), 1);
      chk("t4_ovf_pre", 32'(overflow), 0);
      push(2, 1);
      chk("t4_full", 32'(full), 1);
      chk("t4_count", 32'(count), 4);
      chk("t4_overflow", 32'(overflow), 1);
      chk("t4_top_kept", {pop_var_idx, pop_val}, {4'd4, 1'b1});
      push_en = 1; push_var_idx = 2; push_val = 1; pop_ready = 1;
      tick(); idle();
      chk("t4_repl_count", 32'(count), 4);
      chk("t4_repl_top", {pop_var_idx, pop_val}, {4'd2, 1'b1});
      chk("t4_ovf_sticky", 32'(overflow), 1);
      do_clear();
      chk("t4_clr_count", 32'(count), 0);
      chk("t4_clr_ovf", 32'(overflow), 0);

      // 5: clear beats push and pop
      push(1, 1); push(2, 0); push(3, 1);
      clear = 1; push_en = 1; push_var_idx = 6; push_val = 1; pop_ready = 1;
      tick(); idle();
      chk("t5_count", 32'(count), 0);
      chk("t5_pop_valid", 32'(pop_valid), 0);
      push(11, 0);
      chk("t5_no6", {count, pop_var_idx, pop_val}, {3'd1, 4'd11, 1'b0});

      // reset beats clear, then reset state again
      reset = 1; clear = 1; tick(); reset = 0; idle();
      chk("rst2_count", 32'(count), 0);

      // 6: statistics
      for (int i = 0; i < 5; i++) s_push(4'(i + 1));
      s_pop_ready = 1; tick(); tick(); tick(); s_pop_ready = 0;
      s_push(9);
      chk("t6_count", 32'(s_count), 3);
`ifdef IMPLY_STACK_STATS_EN
      chk("t6_high_water", 32'(s_high_water), 5);
      chk("t6_push_total", 32'(s_push_total), 6);
`else
      chk("t6_high_water_tied", 32'(s_high_water), 0);
      chk("t6_push_total_tied", 32'(s_push_total), 0);
`endif
      s_clear = 1; tick(); s_clear = 0;
      chk("t6_clr_count", 32'(s_count), 0);
      chk("t6_clr_high_water", 32'(s_high_water), 0);
`ifdef IMPLY_STACK_STATS_EN
      chk("t6_clr_push_total", 32'(s_push_total), 6);
`else
      chk("t6_clr_push_total_tied", 32'(s_push_total), 0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
